// File: rtl/gpu_frame_scheduler_if.sv
// Command stream and vertex-memory write port shared between the host side
// and the frame scheduler.
interface gpu_frame_scheduler_if #(
  parameter int W  = 18,
  parameter int AW = 14
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_type;
  logic [W-1:0]  cmd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [W-1:0]  mem_wr_data;

  modport master (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/gpu_frame_scheduler.sv
// GPU frame front-end: loads matrix/vertex words from a command stream, kicks a
// frame with a double-buffered transform matrix and waits for completion under a watchdog.
module gpu_frame_scheduler #(
  parameter int W       = 18,
  parameter int DEPTH   = 16384,
  parameter int TIMEOUT = 2**24
) (
  input  logic                clk,
  input  logic                reset,
  gpu_frame_scheduler_if.slave bus,
  output logic [16*W-1:0]     transform_matrix,
  output logic [31:0]         vertex_count,
  output logic                start,
  input  logic                frame_end,
  output logic                busy,
  output logic                done,
  output logic                err_overflow,
  output logic                err_empty,
  output logic                err_timeout,
  output logic [15:0]         frame_cnt
);
  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]    DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [1:0] CMD_MATRIX = 2'd0;
  localparam logic [1:0] CMD_VERTEX = 2'd1;
  localparam logic [1:0] CMD_KICK   = 2'd2;
  localparam logic [1:0] CMD_CLEAR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_KICK, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;

  logic                r_mem_wr_en;
  logic [AW-1:0]       r_mem_wr_addr;
  logic [W-1:0]        r_mem_wr_data;
  logic [AW:0]         r_vptr;
  logic [3:0]          r_mptr;
  logic [WDW-1:0]      r_wd;
  logic [31:0]         r_vcount;
  logic                r_err_overflow, r_err_empty, r_err_timeout;
  logic [15:0]         r_frame_cnt;
  logic signed [W-1:0] r_shadow [16];
  logic signed [W-1:0] r_active [16];

  logic        w_accept, w_full, w_kick_empty, w_wd_expire;
  logic [AW:0] w_kick_cnt;

  // Frames are rendered in whole quads; leftover vertices are not counted.
  assign w_kick_cnt   = {r_vptr[AW:2], 2'b00};
  assign w_kick_empty = (w_kick_cnt == '0);
  assign w_full       = (r_vptr == DEPTH_V);
  assign w_accept     = bus.cmd_valid && (r_state == S_IDLE);
  assign w_wd_expire  = (r_wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.cmd_ready = 1'b0;
    start         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (w_accept && bus.cmd_type == CMD_KICK)
          w_next = w_kick_empty ? S_DONE : S_KICK;
      end
      S_KICK: begin
        start  = 1'b1;
        busy   = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (frame_end || w_wd_expire) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_wr_en    <= 1'b0;
      r_mem_wr_addr  <= '0;
      r_mem_wr_data  <= '0;
      r_vptr         <= '0;
      r_mptr         <= '0;
      r_wd           <= '0;
      r_vcount       <= '0;
      r_err_overflow <= 1'b0;
      r_err_empty    <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_frame_cnt    <= '0;
      for (int i = 0; i < 16; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_mem_wr_en <= 1'b0;
      if (w_accept) begin
        case (bus.cmd_type)
          CMD_MATRIX: begin
            r_shadow[r_mptr] <= bus.cmd_data;
            r_mptr           <= r_mptr + 4'd1;
          end
          CMD_VERTEX: begin
            if (w_full) begin
              r_err_overflow <= 1'b1;
            end else begin
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_addr <= r_vptr[AW-1:0];
              r_mem_wr_data <= bus.cmd_data;
              r_vptr        <= r_vptr + 1'b1;
            end
          end
          CMD_KICK: begin
            if (w_kick_empty) begin
              r_err_empty <= 1'b1;
            end else begin
              r_vcount <= 32'(w_kick_cnt);
              r_active <= r_shadow;
            end
          end
          CMD_CLEAR: begin
            r_vptr         <= '0;
            r_mptr         <= '0;
            r_err_overflow <= 1'b0;
            r_err_empty    <= 1'b0;
            r_err_timeout  <= 1'b0;
          end
        endcase
      end

      // Watchdog only runs while waiting for the rasterizer.
      if (r_state == S_RUN) begin
        r_wd <= r_wd + 1'b1;
        if (frame_end)        r_frame_cnt   <= r_frame_cnt + 16'd1;
        else if (w_wd_expire) r_err_timeout <= 1'b1;
      end else begin
        r_wd <= '0;
      end

      if (r_state == S_DONE) begin
        r_vptr <= '0;
        r_mptr <= '0;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign transform_matrix[g*W +: W] = r_active[g];
  end

  assign bus.mem_wr_en   = r_mem_wr_en;
  assign bus.mem_wr_addr = r_mem_wr_addr;
  assign bus.mem_wr_data = r_mem_wr_data;
  assign vertex_count    = r_vcount;
  assign err_overflow    = r_err_overflow;
  assign err_empty       = r_err_empty;
  assign err_timeout     = r_err_timeout;
  assign frame_cnt       = r_frame_cnt;
endmodule

// File: tb/tb_gpu_frame_scheduler.sv
// Bench for gpu_frame_scheduler: directed frame scenarios with literal expectations,
// then randomized command traffic compared each cycle against a timeline model.
module tb_gpu_frame_scheduler;
  localparam int W       = 18;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 100;
  localparam int AW      = 4;
  localparam int BIG     = 32'h3fff_ffff;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_end;
  logic [16*W-1:0] transform_matrix;
  logic [31:0]     vertex_count;
  logic            start, busy, done;
  logic            err_overflow, err_empty, err_timeout;
  logic [15:0]     frame_cnt;

  gpu_frame_scheduler_if #(.W(W), .AW(AW)) bus ();

  gpu_frame_scheduler #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .transform_matrix(transform_matrix), .vertex_count(vertex_count),
    .start(start), .frame_end(frame_end), .busy(busy), .done(done),
    .err_overflow(err_overflow), .err_empty(err_empty), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is a window of cycle numbers [kick_at, done_at].
  int          cyc     = 0;
  int          kick_at = -10;
  int          done_at = -10;
  bit          m_ok    = 1'b0;
  int          m_vptr, m_mptr;
  logic [W-1:0]  m_shadow [16];
  logic [W-1:0]  m_active [16];
  logic [31:0]   m_vcount;
  bit            m_eo, m_ee, m_et;
  logic [15:0]   m_fcnt;
  bit            m_wen;
  logic [AW-1:0] m_waddr;
  logic [W-1:0]  m_wdata;

  task automatic finish_frame(input int p);
    done_at = p + 1;
    m_vptr  = 0;
    m_mptr  = 0;
  endtask

  task automatic model_update();
    int p;
    int quad;
    p = cyc;
    cyc++;
    if (reset) begin
      kick_at = -10; done_at = -10;
      m_vptr = 0; m_mptr = 0; m_vcount = '0;
      m_eo = 0; m_ee = 0; m_et = 0; m_fcnt = '0;
      m_wen = 0; m_waddr = '0; m_wdata = '0;
      for (int i = 0; i < 16; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
      m_ok = 1'b1;
      return;
    end
    m_wen = 0;
    if (p > kick_at && p < done_at) begin
      if (frame_end) begin
        m_fcnt++;
        finish_frame(p);
      end else if (p == kick_at + TIMEOUT) begin
        m_et = 1;
        finish_frame(p);
      end
    end else if (p > done_at && bus.cmd_valid) begin
      case (bus.cmd_type)
        2'd0: begin m_shadow[m_mptr] = bus.cmd_data; m_mptr = (m_mptr + 1) % 16; end
        2'd1: begin
          if (m_vptr == DEPTH) m_eo = 1;
          else begin m_wen = 1; m_waddr = AW'(m_vptr); m_wdata = bus.cmd_data; m_vptr++; end
        end
        2'd2: begin
          quad = (m_vptr / 4) * 4;
          if (quad == 0) begin
            m_ee = 1;
            finish_frame(p);
          end else begin
            m_vcount = 32'(quad);
            m_active = m_shadow;
            kick_at  = p + 1;
            done_at  = BIG;
          end
        end
        default: begin m_vptr = 0; m_mptr = 0; m_eo = 0; m_ee = 0; m_et = 0; end
      endcase
    end
  endtask

  task automatic step(input bit v, input logic [1:0] t, input logic [W-1:0] d,
                      input bit fe, input bit rst);
    bus.cmd_valid = v;
    bus.cmd_type  = t;
    bus.cmd_data  = d;
    frame_end     = fe;
    reset         = rst;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [16*W-1:0] tm;
    @(negedge clk);
    if (m_ok) begin
      for (int i = 0; i < 16; i++) tm[i*W +: W] = m_active[i];
      check("cmd_ready", bus.cmd_ready, cyc > done_at);
      check("start", start, cyc == kick_at);
      check("busy", busy, (cyc >= kick_at) && (cyc < done_at));
      check("done", done, cyc == done_at);
      check("vertex_count", vertex_count, m_vcount);
      check("transform_matrix", transform_matrix, tm);
      check("err_overflow", err_overflow, m_eo);
      check("err_empty", err_empty, m_ee);
      check("err_timeout", err_timeout, m_et);
      check("frame_cnt", frame_cnt, m_fcnt);
      check("mem_wr_en", bus.mem_wr_en, m_wen);
      if (m_wen) begin
        check("mem_wr_addr", bus.mem_wr_addr, m_waddr);
        check("mem_wr_data", bus.mem_wr_data, m_wdata);
      end
    end
  end

  initial begin
    logic [16*W-1:0] tm_exp;
    int n;
    int writes;
    int x;
    logic [1:0] t;

    bus.cmd_valid = 0; bus.cmd_type = 0; bus.cmd_data = 0;
    frame_end = 0; reset = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);
    check("rst_tm", transform_matrix, 0);
    check("rst_vcount", vertex_count, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_errs", {err_overflow, err_empty, err_timeout}, 0);
    check("rst_wr_en", bus.mem_wr_en, 0);

    // Matrix 0..15, 8 vertices, kick, finish on frame_end.
    for (int i = 0; i < 16; i++) step(1, 2'd0, W'(i), 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 2'd1, W'(32'h100 + i), 0, 0);
      check("t1_wr_en", bus.mem_wr_en, 1);
      check("t1_wr_addr", bus.mem_wr_addr, i);
      check("t1_wr_data", bus.mem_wr_data, 32'h100 + i);
    end
    step(1, 2'd2, 0, 0, 0);
    for (int i = 0; i < 16; i++) tm_exp[i*W +: W] = W'(i);
    check("t1_start", start, 1);
    check("t1_vcount", vertex_count, 8);
    check("t1_tm", transform_matrix, tm_exp);
    check("t1_ready_kick", bus.cmd_ready, 0);
    step(0, 0, 0, 0, 0);
    check("t1_start_single", start, 0);
    check("t1_busy_run", busy, 1);
    repeat (10) step(0, 0, 0, 0, 0);
    check("t1_busy_late", busy, 1);
    step(0, 0, 0, 1, 0);
    check("t1_done", done, 1);
    check("t1_fcnt", frame_cnt, 1);
    check("t1_busy_done", busy, 0);
    step(0, 0, 0, 0, 0);
    check("t1_ready_after", bus.cmd_ready, 1);

    // 6 vertices round down to one quad of 4.
    for (int i = 0; i < 6; i++) step(1, 2'd1, W'(i), 0, 0);
    step(1, 2'd2, 0, 0, 0);
    check("t2_vcount", vertex_count, 4);
    repeat (50) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("t2_done", done, 1);
    check("t2_fcnt", frame_cnt, 2);
    step(0, 0, 0, 0, 0);
    check("t2_ready", bus.cmd_ready, 1);

    // Kick with too few vertices.
    step(1, 2'd3, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 2'd1, W'(i), 0, 0);
    step(1, 2'd2, 0, 0, 0);
    check("t3_done", done, 1);
    check("t3_no_start", start, 0);
    check("t3_err_empty", err_empty, 1);
    step(0, 0, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    check("t3_clear", err_empty, 0);

    // Overflow: 17 vertices into a 16-deep memory.
    writes = 0;
    for (int i = 0; i < 17; i++) begin
      step(1, 2'd1, W'(32'h200 + i), 0, 0);
      if (bus.mem_wr_en) writes++;
      if (i == 15) check("t4_no_ovf_yet", err_overflow, 0);
    end
    check("t4_last_no_write", bus.mem_wr_en, 0);
    check("t4_err_overflow", err_overflow, 1);
    check("t4_writes", writes, 16);

    // Watchdog: no frame_end, done 100 cycles after RUN entry.
    step(1, 2'd3, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2'd1, W'(i), 0, 0);
    step(1, 2'd2, 0, 0, 0);
    n = 0;
    do begin
      step(0, 0, 0, 0, 0);
      n++;
    end while (!done && n < 200);
    check("t5_latency_from_kick", n, 101);
    check("t5_err_timeout", err_timeout, 1);
    check("t5_fcnt", frame_cnt, 2);

    // Commands offered during RUN are refused and leave the shadow intact.
    step(1, 2'd3, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 2'd0, W'(32'h3000 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2'd1, W'(i), 0, 0);
    step(1, 2'd2, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'(i % 2), W'(32'h1555), 0, 0);
      check("t6_ready_run", bus.cmd_ready, 0);
      check("t6_no_write", bus.mem_wr_en, 0);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2'd1, W'(i), 0, 0);
    step(1, 2'd2, 0, 0, 0);
    check("t6_shadow_kept", transform_matrix[W-1:0], 32'h3000);
    check("t6_shadow_kept_hi", transform_matrix[15*W +: W], 32'h300f);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_start", start, 0);
    check("t6_rst_tm", transform_matrix, 0);
    step(0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      x = $urandom_range(0, 99);
      t = (x < 35) ? 2'd0 : (x < 85) ? 2'd1 : (x < 93) ? 2'd2 : 2'd3;
      step($urandom_range(0, 99) < 70, t, W'($urandom),
           $urandom_range(0, 59) == 0, $urandom_range(0, 999) == 0);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
